mac_decoder: RTL and testbench

Receive-side Ethernet II frame decoder; the counterpart of the transmit MAC header coder. Consumes a byte stream with preamble/SFD and FCS already stripped, parses the 14-byte MAC header, filters on destination address and EtherType, and forwards payload bytes to the ARP or IP receive handler. Sits between the RX byte interface of the PHY adapter and the ARP/IP parsers.

---
 rtl/mac_pkg.sv | 51 +++++
 rtl/mac_rx_stats.sv | 26 ++
 rtl/mac_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_mac_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the Ethernet II receive decoder.
// Holds header geometry, EtherType and ARP_TYPE codes, the broadcast and
// default station address, the decoder state encoding and the header payload
// struct. Optional feature macro used by the decoder: MAC_DECODER_STATS_EN.
package mac_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned ADDR_W    = 48;
  localparam int unsigned TYPE_W    = 16;
  localparam int unsigned HDR_W     = 112;
  localparam int unsigned SHADOW_W  = HDR_W - BYTE_W;
  localparam int unsigned HDR_BYTES = 14;
  localparam int unsigned DST_BYTES = 6;
  localparam int unsigned BCNT_W    = 4;
  localparam int unsigned CNT_W     = 16;
  localparam int unsigned ATYPE_W   = 2;

  localparam logic [ADDR_W-1:0] DEFAULT_MAC_ADDR = 48'h00_0A_35_00_00_01;
  localparam logic [ADDR_W-1:0] BCAST_ADDR       = 48'hFF_FF_FF_FF_FF_FF;

  localparam logic [TYPE_W-1:0] ETH_ARP  = 16'h0806;
  localparam logic [TYPE_W-1:0] ETH_RARP = 16'h8035;
  localparam logic [TYPE_W-1:0] ETH_IP   = 16'h0800;

  localparam logic [ATYPE_W-1:0] ARP_CODE  = 2'b01;
  localparam logic [ATYPE_W-1:0] RARP_CODE = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DROP    = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Header layout as it appears on MAC_HEADER: dst in the MSBs.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src;
    logic [TYPE_W-1:0] ethertype;
  } mac_hdr_t;

  // Octet idx of an address, octet 0 being the first on the wire.
  function automatic logic [BYTE_W-1:0] addr_octet(input logic [ADDR_W-1:0] addr,
                                                   input logic [BCNT_W-1:0] idx);
    logic [ADDR_W-1:0] sh;
    sh = addr << {idx, 3'b000};
    return sh[ADDR_W-1 -: BYTE_W];
  endfunction

endpackage

// File: rtl/mac_rx_stats.sv
// Saturating receive statistics.
// Ports: clk, rst_n (async active-low), accept/drop one-cycle strobes in,
// frame_cnt/drop_cnt 16-bit saturating counts out (cleared only by reset).
module mac_rx_stats
  import mac_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic             drop,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  // Both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept && (frame_cnt != '1)) frame_cnt <= frame_cnt + CNT_W'(1);
      if (drop && (drop_cnt != '1))    drop_cnt  <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mac_decoder.sv
// Ethernet II receive frame decoder: parses the 14-byte MAC header, filters
// on destination (own address or broadcast) and EtherType, and forwards the
// payload to the ARP/RARP or IP path with one cycle of latency.
// Ports: clk, rst_n (async active-low); in_data/in_data_vld byte stream;
// mac_header/hdr_vld captured header; arp_en/arp_type/arp_data/arp_done and
// ip_en/ip_data/ip_done payload paths; rx_frame_cnt/rx_drop_cnt statistics.
// Optional: define MAC_DECODER_STATS_EN to build the statistics counters;
// otherwise both count ports read zero.
module mac_decoder
  import mac_pkg::*;
#(
  parameter logic [ADDR_W-1:0] HTGv6_MAC_ADDR = DEFAULT_MAC_ADDR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_data_vld,
  output logic [HDR_W-1:0]   mac_header,
  output logic               hdr_vld,
  output logic               arp_en,
  output logic [ATYPE_W-1:0] arp_type,
  output logic [BYTE_W-1:0]  arp_data,
  output logic               arp_done,
  output logic               ip_en,
  output logic [BYTE_W-1:0]  ip_data,
  output logic               ip_done,
  output logic [CNT_W-1:0]   rx_frame_cnt,
  output logic [CNT_W-1:0]   rx_drop_cnt
);

  state_t                state_q, state_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic [BCNT_W-1:0]     cnt_q, cnt_d;
  logic                  own_q, own_d;
  logic                  bcast_q, bcast_d;
  logic                  sel_arp_q, sel_arp_d;

  logic                  hdr_take;
  logic                  fwd_byte;
  logic                  frame_end;
  logic                  drop_evt;

  mac_hdr_t              hdr_next;
  logic                  own_hit;
  logic                  bcast_hit;
  logic                  is_arp;
  logic                  is_ip;

  // Header as it would stand once the current byte is appended.
  assign hdr_next  = mac_hdr_t'({shadow_q, in_data});
  assign is_arp    = (hdr_next.ethertype == ETH_ARP) || (hdr_next.ethertype == ETH_RARP);
  assign is_ip     = (hdr_next.ethertype == ETH_IP);
  // cnt_q is zero in IDLE, so these compare against octet 0 there.
  assign own_hit   = (in_data == addr_octet(HTGv6_MAC_ADDR, cnt_q));
  assign bcast_hit = (in_data == addr_octet(BCAST_ADDR, cnt_q));

  // State and header-parse registers; reset lands in DROP so a frame in
  // flight at reset release is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_DROP;
      shadow_q  <= '0;
      cnt_q     <= '0;
      own_q     <= 1'b0;
      bcast_q   <= 1'b0;
      sel_arp_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      own_q     <= own_d;
      bcast_q   <= bcast_d;
      sel_arp_q <= sel_arp_d;
    end
  end

  // Next state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = '0;
    own_d     = own_q;
    bcast_d   = bcast_q;
    sel_arp_d = sel_arp_q;
    hdr_take  = 1'b0;
    fwd_byte  = 1'b0;
    frame_end = 1'b0;
    drop_evt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_data_vld) begin
          state_d  = ST_HDR;
          cnt_d    = BCNT_W'(1);
          shadow_d = {shadow_q[SHADOW_W-BYTE_W-1:0], in_data};
          own_d    = own_hit;
          bcast_d  = bcast_hit;
        end
      end

      ST_HDR: begin
        if (!in_data_vld) begin
          // Runt: frame ended inside the header.
          state_d  = ST_IDLE;
          drop_evt = 1'b1;
        end else begin
          shadow_d = {shadow_q[SHADOW_W-BYTE_W-1:0], in_data};
          if (cnt_q < BCNT_W'(DST_BYTES)) begin
            own_d   = own_q & own_hit;
            bcast_d = bcast_q & bcast_hit;
          end
          if (cnt_q == BCNT_W'(HDR_BYTES - 1)) begin
            // Destination flags are final since octet 5.
            if ((own_q || bcast_q) && (is_arp || is_ip)) begin
              state_d   = ST_PAYLOAD;
              hdr_take  = 1'b1;
              sel_arp_d = is_arp;
            end else begin
              state_d  = ST_DROP;
              drop_evt = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + BCNT_W'(1);
          end
        end
      end

      ST_PAYLOAD: begin
        if (in_data_vld) begin
          fwd_byte = 1'b1;
        end else begin
          state_d   = ST_DONE;
          frame_end = 1'b1;
        end
      end

      ST_DONE: begin
        // A byte here means the inter-frame gap was too short.
        if (in_data_vld) begin
          state_d  = ST_DROP;
          drop_evt = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DROP: begin
        if (!in_data_vld) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_DROP;
      end
    endcase
  end

  // Registered outputs; data of each path only moves when that path forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_header <= '0;
      hdr_vld    <= 1'b0;
      arp_en     <= 1'b0;
      arp_type   <= '0;
      arp_data   <= '0;
      arp_done   <= 1'b0;
      ip_en      <= 1'b0;
      ip_data    <= '0;
      ip_done    <= 1'b0;
    end else begin
      hdr_vld  <= hdr_take;
      arp_en   <= fwd_byte & sel_arp_q;
      ip_en    <= fwd_byte & ~sel_arp_q;
      arp_done <= frame_end & sel_arp_q;
      ip_done  <= frame_end & ~sel_arp_q;
      if (hdr_take) begin
        mac_header <= hdr_next;
        if (is_arp) arp_type <= (hdr_next.ethertype == ETH_RARP) ? RARP_CODE : ARP_CODE;
      end
      if (fwd_byte && sel_arp_q)  arp_data <= in_data;
      if (fwd_byte && !sel_arp_q) ip_data  <= in_data;
    end
  end

`ifdef MAC_DECODER_STATS_EN
  mac_rx_stats u_stats (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (frame_end),
    .drop      (drop_evt),
    .frame_cnt (rx_frame_cnt),
    .drop_cnt  (rx_drop_cnt)
  );
`else
  logic unused_drop_evt;
  assign unused_drop_evt = drop_evt;
  assign rx_frame_cnt    = '0;
  assign rx_drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_mac_decoder.sv
// Self-checking bench for mac_decoder: directed and randomized frames checked
// against a frame-level reference model (filter rules, gap rule, latency 1).
module tb_mac_decoder;

  localparam logic [47:0] OWN   = 48'h00_0A_35_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
`ifdef MAC_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   in_data = 8'h00;
  logic         in_data_vld = 1'b0;
  logic [111:0] mac_header;
  logic         hdr_vld;
  logic         arp_en;
  logic [1:0]   arp_type;
  logic [7:0]   arp_data;
  logic         arp_done;
  logic         ip_en;
  logic [7:0]   ip_data;
  logic         ip_done;
  logic [15:0]  rx_frame_cnt;
  logic [15:0]  rx_drop_cnt;

  mac_decoder #(.HTGv6_MAC_ADDR(OWN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_data      (in_data),
    .in_data_vld  (in_data_vld),
    .mac_header   (mac_header),
    .hdr_vld      (hdr_vld),
    .arp_en       (arp_en),
    .arp_type     (arp_type),
    .arp_data     (arp_data),
    .arp_done     (arp_done),
    .ip_en        (ip_en),
    .ip_data      (ip_data),
    .ip_done      (ip_done),
    .rx_frame_cnt (rx_frame_cnt),
    .rx_drop_cnt  (rx_drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed events, each tagged with the cycle it appeared in.
  logic [143:0] got_hdr[$];
  logic [39:0]  got_arp[$];
  logic [39:0]  got_ip[$];
  int           got_arp_done[$];
  int           got_ip_done[$];
  int           overlap = 0;

  always @(negedge clk) begin
    if (hdr_vld)  got_hdr.push_back({32'(cyc), mac_header});
    if (arp_en)   got_arp.push_back({32'(cyc), arp_data});
    if (ip_en)    got_ip.push_back({32'(cyc), ip_data});
    if (arp_done) got_arp_done.push_back(cyc);
    if (ip_done)  got_ip_done.push_back(cyc);
    if ((arp_en && arp_done) || (ip_en && ip_done) || (arp_en && ip_en) ||
        (arp_done && ip_done)) overlap++;
  end

  // Reference model state.
  logic [143:0] exp_hdr[$];
  logic [39:0]  exp_arp[$];
  logic [39:0]  exp_ip[$];
  int           exp_arp_done[$];
  int           exp_ip_done[$];
  int           exp_frames = 0;
  int           exp_drops = 0;
  logic [1:0]   exp_arp_type = 2'b00;
  bit           prev_ok = 1'b0;
  int           prev_gap = 8;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_exp(input int n);
    logic [15:0] sat;
    sat = (n > 65535) ? 16'hFFFF : 16'(n);
    return STATS ? sat : 16'h0000;
  endfunction

  function automatic bq_t mk_frame(input logic [47:0] dst, input logic [47:0] src,
                                   input logic [15:0] et, input int plen, input bit seq);
    bq_t q;
    logic [111:0] h;
    h = {dst, src, et};
    for (int i = 0; i < 14; i++) q.push_back(h[111-8*i -: 8]);
    for (int i = 0; i < plen; i++) q.push_back(seq ? 8'(i) : 8'($urandom));
    return q;
  endfunction

  // Drive one frame followed by `gap` idle cycles and record what the
  // decoder must produce for it.
  task automatic play(input bq_t frm, input int gap);
    bit ok;
    bit arp;
    int n;
    logic [47:0]  dst;
    logic [15:0]  et;
    logic [111:0] hdr;
    n   = frm.size();
    dst = '0;
    et  = '0;
    hdr = '0;
    for (int i = 0; i < n && i < 14; i++) hdr = {hdr[103:0], frm[i]};
    dst = hdr[111:64];
    et  = hdr[15:0];
    arp = (et == 16'h0806) || (et == 16'h8035);
    ok  = !(prev_ok && prev_gap < 2) && (n >= 14) && (dst == OWN || dst == BCAST) &&
          (arp || et == 16'h0800);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_data     = frm[i];
      in_data_vld = 1'b1;
      if (ok && i == 13) exp_hdr.push_back({32'(cyc + 1), hdr});
      if (ok && i >= 14) begin
        if (arp) exp_arp.push_back({32'(cyc + 1), frm[i]});
        else     exp_ip.push_back({32'(cyc + 1), frm[i]});
      end
    end
    @(posedge clk); #1;
    in_data_vld = 1'b0;
    in_data     = 8'($urandom);
    if (ok) begin
      exp_frames++;
      if (arp) begin
        exp_arp_done.push_back(cyc + 1);
        exp_arp_type = (et == 16'h8035) ? 2'b10 : 2'b01;
      end else begin
        exp_ip_done.push_back(cyc + 1);
      end
    end else begin
      exp_drops++;
    end
    for (int g = 1; g < gap; g++) begin
      @(posedge clk); #1;
      in_data = 8'($urandom);
    end
    prev_ok  = ok;
    prev_gap = gap;
  endtask

  task automatic clear_q();
    got_hdr.delete(); got_arp.delete(); got_ip.delete();
    got_arp_done.delete(); got_ip_done.delete();
    exp_hdr.delete(); exp_arp.delete(); exp_ip.delete();
    exp_arp_done.delete(); exp_ip_done.delete();
    overlap = 0;
  endtask

  task automatic check_scn(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " hdr_count"}, 160'(got_hdr.size()), 160'(exp_hdr.size()));
    for (int i = 0; i < got_hdr.size() && i < exp_hdr.size(); i++)
      chk({tag, " hdr"}, 160'(got_hdr[i]), 160'(exp_hdr[i]));
    chk({tag, " arp_count"}, 160'(got_arp.size()), 160'(exp_arp.size()));
    for (int i = 0; i < got_arp.size() && i < exp_arp.size(); i++)
      chk({tag, " arp_byte"}, 160'(got_arp[i]), 160'(exp_arp[i]));
    chk({tag, " ip_count"}, 160'(got_ip.size()), 160'(exp_ip.size()));
    for (int i = 0; i < got_ip.size() && i < exp_ip.size(); i++)
      chk({tag, " ip_byte"}, 160'(got_ip[i]), 160'(exp_ip[i]));
    chk({tag, " arp_done_count"}, 160'(got_arp_done.size()), 160'(exp_arp_done.size()));
    for (int i = 0; i < got_arp_done.size() && i < exp_arp_done.size(); i++)
      chk({tag, " arp_done_cycle"}, 160'(got_arp_done[i]), 160'(exp_arp_done[i]));
    chk({tag, " ip_done_count"}, 160'(got_ip_done.size()), 160'(exp_ip_done.size()));
    for (int i = 0; i < got_ip_done.size() && i < exp_ip_done.size(); i++)
      chk({tag, " ip_done_cycle"}, 160'(got_ip_done[i]), 160'(exp_ip_done[i]));
    chk({tag, " overlap"}, 160'(overlap), 160'(0));
    chk({tag, " arp_type"}, 160'(arp_type), 160'(exp_arp_type));
    chk({tag, " frame_cnt"}, 160'(rx_frame_cnt), 160'(cnt_exp(exp_frames)));
    chk({tag, " drop_cnt"}, 160'(rx_drop_cnt), 160'(cnt_exp(exp_drops)));
    chk({tag, " idle_strobes"}, 160'({hdr_vld, arp_en, ip_en, arp_done, ip_done}), 160'(0));
    clear_q();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " mac_header"}, 160'(mac_header), 160'(0));
    chk({tag, " strobes"}, 160'({hdr_vld, arp_en, arp_done, ip_en, ip_done}), 160'(0));
    chk({tag, " arp_type"}, 160'(arp_type), 160'(0));
    chk({tag, " arp_data"}, 160'(arp_data), 160'(0));
    chk({tag, " ip_data"}, 160'(ip_data), 160'(0));
    chk({tag, " counters"}, 160'({rx_frame_cnt, rx_drop_cnt}), 160'(0));
  endtask

  initial begin
    bq_t f;
    bq_t f2;
    logic [47:0] d;
    logic [15:0] t;
    int len;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_q();

    // ARP broadcast, sequential payload 0x00..0x1B
    f = mk_frame(BCAST, 48'h00_11_22_33_44_55, 16'h0806, 28, 1'b1);
    play(f, 3);
    check_scn("arp_bcast");

    // Unicast IP to own address
    f = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h0800, 20, 1'b0);
    play(f, 3);
    check_scn("ip_unicast");

    // Filter misses: wrong destination, unsupported EtherType
    f = mk_frame(48'h00_0A_35_00_00_02, 48'h00_11_22_33_44_55, 16'h0806, 10, 1'b0);
    play(f, 3);
    f = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h86DD, 10, 1'b0);
    play(f, 3);
    check_scn("filter_miss");

    // Runt of 9 bytes, then a normal RARP frame
    f = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h8035, 0, 1'b0);
    while (f.size() > 9) void'(f.pop_back());
    play(f, 2);
    f = mk_frame(OWN, 48'h66_77_88_99_AA_BB, 16'h8035, 12, 1'b0);
    play(f, 3);
    check_scn("runt_then_rarp");

    // Header-only accepted frame
    f = mk_frame(BCAST, 48'h12_34_56_78_9A_BC, 16'h0800, 0, 1'b0);
    play(f, 3);
    check_scn("hdr_only");

    // Reset asserted mid-payload and released with the frame still running
    f = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h0800, 20, 1'b0);
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      in_data     = f[i];
      in_data_vld = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("in_reset");
    clear_q();
    repeat (2) begin
      @(posedge clk); #1;
      in_data = 8'($urandom);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      in_data = 8'($urandom);
    end
    @(posedge clk); #1;
    in_data_vld = 1'b0;
    repeat (2) @(posedge clk);
    exp_frames   = 0;
    exp_drops    = 0;
    exp_arp_type = 2'b00;
    prev_ok      = 1'b0;
    prev_gap     = 8;
    check_scn("reset_mid_frame");
    f = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h0806, 8, 1'b0);
    play(f, 3);
    check_scn("after_reset");

    // One-cycle gap loses the second frame, two-cycle gap keeps both
    f  = mk_frame(OWN, 48'h00_11_22_33_44_55, 16'h0806, 6, 1'b0);
    f2 = mk_frame(OWN, 48'h00_11_22_33_44_56, 16'h0800, 6, 1'b0);
    play(f, 1);
    play(f2, 3);
    check_scn("gap1");
    play(f, 2);
    play(f2, 3);
    check_scn("gap2");

    // Random batches with random gaps
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 5; k++) begin
        case ($urandom_range(0, 3))
          0:       d = OWN;
          1:       d = BCAST;
          2:       d = {8'h02, 40'($urandom)};
          default: d = OWN ^ (48'h1 << $urandom_range(0, 47));
        endcase
        case ($urandom_range(0, 4))
          0:       t = 16'h0806;
          1:       t = 16'h8035;
          2:       t = 16'h0800;
          3:       t = 16'h86DD;
          default: t = 16'($urandom);
        endcase
        f = mk_frame(d, {16'($urandom), 32'($urandom)}, t, $urandom_range(0, 30), 1'b0);
        if ($urandom_range(0, 5) == 0) begin
          len = $urandom_range(1, 13);
          while (f.size() > len) void'(f.pop_back());
        end
        play(f, (k == 4) ? 3 : $urandom_range(1, 3));
      end
      check_scn("random_batch");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
